// File: rtl/seg_pkg.sv
// Shared segment-bus definitions: active-low g..a patterns for 0-9 and blank,
// recovered-digit codes, and the scan FSM state type.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIG_BLANK   = 4'hF;
    localparam logic [3:0] DIG_ILLEGAL = 4'hE;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HELD
    } scan_state_t;

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// Combinational inverse of the BCD->segment encoder: active-low g..a pattern to
// nibble, with err set for any pattern the encoder never produces.
module seg_pattern_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        nibble = DIG_ILLEGAL;
        err    = 1'b0;
        case (pattern)
            SEG_0:     nibble = 4'd0;
            SEG_1:     nibble = 4'd1;
            SEG_2:     nibble = 4'd2;
            SEG_3:     nibble = 4'd3;
            SEG_4:     nibble = 4'd4;
            SEG_5:     nibble = 4'd5;
            SEG_6:     nibble = 4'd6;
            SEG_7:     nibble = 4'd7;
            SEG_8:     nibble = 4'd8;
            SEG_9:     nibble = 4'd9;
            SEG_BLANK: nibble = DIG_BLANK;
            default: begin
                nibble = DIG_ILLEGAL;
                err    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reads back a multiplexed active-low 7-segment bus and recovers the shown digits.
// Optional stale-frame watchdog is built when SEG_STALE_TIMEOUT_EN is defined.
//
// state      | meaning
// ST_WAIT    | anode select invalid, or bus still moving
// ST_SETTLE  | one digit selected, counting stable cycles
// ST_HELD    | this dwell already sampled, waiting for the next change
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIG    = 4,
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 1 << 20
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [NDIG-1:0]   an_n,
    input  logic [7:0]        seg_n,
    output logic [4*NDIG-1:0] digit_o,
    output logic [NDIG-1:0]   dp_o,
    output logic [NDIG-1:0]   digit_err,
    output logic              frame_valid,
    output logic              stale
);

    localparam int CW = $clog2(SETTLE + 1);

    if (SETTLE < 2 || TIMEOUT < 2) begin : g_param_check
        $error("seg_scan_decoder: SETTLE and TIMEOUT must both be >= 2");
    end

    logic [NDIG-1:0] an_q, an_p;
    logic [7:0]      seg_q, seg_p;
    scan_state_t     state;
    logic [CW-1:0]   settle_cnt;
    logic [NDIG-1:0] seen;
    logic [3:0]      shadow_dig [NDIG];
    logic [NDIG-1:0] shadow_dp;
    logic [NDIG-1:0] shadow_err;

    logic       an_ok, change, sample, frame_done;
    logic [3:0] dec_nib;
    logic       dec_err;

    seg_pattern_to_bcd u_dec (
        .pattern (seg_q[6:0]),
        .nibble  (dec_nib),
        .err     (dec_err)
    );

    assign an_ok      = $onehot(~an_q);
    assign change     = (an_q != an_p) || (seg_q != seg_p);
    assign sample     = (state == ST_SETTLE) && an_ok && !change
                        && (settle_cnt == CW'(SETTLE - 1));
    assign frame_done = &seen;

`ifdef SEG_STALE_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT) > 20) ? $clog2(TIMEOUT) : 20;
    logic [TW-1:0] to_cnt;
`else
    assign stale = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q        <= '1;
            an_p        <= '1;
            seg_q       <= '1;
            seg_p       <= '1;
            state       <= ST_WAIT;
            settle_cnt  <= '0;
            seen        <= '0;
            shadow_dp   <= '0;
            shadow_err  <= '0;
            digit_o     <= {NDIG{DIG_BLANK}};
            dp_o        <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            for (int i = 0; i < NDIG; i++) shadow_dig[i] <= DIG_BLANK;
`ifdef SEG_STALE_TIMEOUT_EN
            to_cnt      <= '0;
            stale       <= 1'b0;
`endif
        end else begin
            an_q        <= an_n;
            seg_q       <= seg_n;
            an_p        <= an_q;
            seg_p       <= seg_q;
            frame_valid <= 1'b0;

            case (state)
                ST_WAIT: begin
                    if (an_ok && !change) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (change || !an_ok) begin
                        state      <= ST_WAIT;
                        settle_cnt <= '0;
                    end else if (settle_cnt == CW'(SETTLE - 1)) begin
                        state <= ST_HELD;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                ST_HELD: begin
                    // Counting from 0 here matches the WAIT path, which only
                    // reaches count 1 after the first stable cycle.
                    if (change) begin
                        state      <= an_ok ? ST_SETTLE : ST_WAIT;
                        settle_cnt <= '0;
                    end
                end
                default: begin
                    state      <= ST_WAIT;
                    settle_cnt <= '0;
                end
            endcase

            for (int i = 0; i < NDIG; i++) begin
                if (sample && !an_q[i]) begin
                    shadow_dig[i] <= dec_nib;
                    shadow_dp[i]  <= ~seg_q[7];
                    shadow_err[i] <= dec_err;
                end
            end

            if (frame_done) begin
                for (int i = 0; i < NDIG; i++) digit_o[4*i +: 4] <= shadow_dig[i];
                dp_o        <= shadow_dp;
                digit_err   <= shadow_err;
                frame_valid <= 1'b1;
            end
            seen <= (frame_done ? '0 : seen) | (sample ? ~an_q : '0);

`ifdef SEG_STALE_TIMEOUT_EN
            if (frame_done) begin
                to_cnt <= '0;
                stale  <= 1'b0;
            end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                // Partial frame is abandoned once, on the cycle stale rises.
                if (!stale) begin
                    stale <= 1'b1;
                    seen  <= '0;
                end
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hand-built digit patterns over the
// anode/cathode bus and compares recovered digits against hand-computed values.
module tb_seg_scan_decoder;
    import seg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an_n = 4'hF;
    logic [7:0]  seg_n = 8'hFF;
    logic [15:0] digit_o;
    logic [3:0]  dp_o;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        stale;

    int n_vec = 0;
    int n_err = 0;
    int fv_count = 0;
    int fv_base = 0;

    seg_scan_decoder #(.NDIG(4), .SETTLE(8), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .digit_o     (digit_o),
        .dp_o        (dp_o),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        if (frame_valid) fv_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dwell(input logic [3:0] an, input logic [7:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        tick(n);
    endtask

    task automatic do_reset();
        an_n  = 4'hF;
        seg_n = 8'hFF;
        rst   = 1'b1;
        tick(2);
        rst   = 1'b0;
    endtask

    task automatic scan4(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        fv_base = fv_count;
        dwell(4'hE, s0, 16);
        dwell(4'hD, s1, 16);
        dwell(4'hB, s2, 16);
        dwell(4'h7, s3, 16);
        dwell(4'hF, 8'hFF, 4);
    endtask

    initial begin
        tick(1);
        do_reset();
        check("rst_digit", digit_o, 16'hFFFF);
        check("rst_dp", dp_o, 4'h0);
        check("rst_err", digit_err, 4'h0);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_stale", stale, 1'b0);

        // 1,2,3,4 in order
        scan4(8'hF9, 8'hA4, 8'hB0, 8'h99);
        check("scan_fv", fv_count - fv_base, 1);
        check("scan_digit", digit_o, 16'h4321);
        check("scan_dp", dp_o, 4'h0);
        check("scan_err", digit_err, 4'h0);

        // short dwell on digit 0 must not be sampled
        fv_base = fv_count;
        dwell(4'hE, 8'h92, 5);
        dwell(4'hD, 8'h82, 16);
        dwell(4'hB, 8'hF8, 16);
        dwell(4'h7, 8'h80, 16);
        check("short_nofv", fv_count - fv_base, 0);
        dwell(4'hE, 8'h92, 16);
        dwell(4'hF, 8'hFF, 4);
        check("short_fv", fv_count - fv_base, 1);
        check("short_digit", digit_o, 16'h8765);

        // two anodes active
        fv_base = fv_count;
        dwell(4'hC, 8'hC0, 20);
        check("dual_fv", fv_count - fv_base, 0);
        check("dual_state", 32'(dut.state), 32'(ST_WAIT));
        check("dual_seen", dut.seen, 4'h0);
        dwell(4'hF, 8'hFF, 4);

        // blank on digit 2
        scan4(8'hC0, 8'hF9, 8'hFF, 8'hA4);
        check("blank_digit", digit_o, 16'h2F10);
        check("blank_err", digit_err, 4'h0);

        // dp-only pattern on digit 2, dp also on digit 0
        scan4(8'h40, 8'hF9, 8'h7F, 8'hA4);
        check("dpblank_digit", digit_o, 16'h2F10);
        check("dpblank_dp", dp_o, 4'h5);

        // all segments plus dp on digit 2
        scan4(8'hC0, 8'hF9, 8'h00, 8'hA4);
        check("eight_digit", digit_o, 16'h2810);
        check("eight_dp", dp_o, 4'h4);

        // illegal pattern on digit 2
        scan4(8'hC0, 8'hF9, 8'hAA, 8'hA4);
        check("illegal_digit", digit_o, 16'h2E10);
        check("illegal_err", digit_err, 4'h4);
        check("illegal_dp", dp_o, 4'h0);

        // reset after three digits sampled
        fv_base = fv_count;
        dwell(4'hE, 8'h90, 16);
        dwell(4'hD, 8'h80, 16);
        dwell(4'hB, 8'hF8, 16);
        do_reset();
        check("midrst_digit", digit_o, 16'hFFFF);
        check("midrst_err", digit_err, 4'h0);
        check("midrst_fv", fv_count - fv_base, 0);
        dwell(4'h7, 8'h99, 16);
        dwell(4'hF, 8'hFF, 4);
        check("midrst_partial", fv_count - fv_base, 0);
        scan4(8'hF9, 8'hA4, 8'hB0, 8'h99);
        check("midrst_fv1", fv_count - fv_base, 1);
        check("midrst_scan", digit_o, 16'h4321);

        // out of order, digit 1 resampled (last wins)
        fv_base = fv_count;
        dwell(4'h7, 8'h99, 16);
        dwell(4'hD, 8'hF9, 16);
        dwell(4'hD, 8'hA4, 16);
        dwell(4'hE, 8'hB0, 16);
        dwell(4'hB, 8'hC0, 16);
        dwell(4'hF, 8'hFF, 4);
        check("ooo_fv", fv_count - fv_base, 1);
        check("ooo_digit", digit_o, 16'h4023);

        // stale watchdog
        do_reset();
        tick(63);
        check("stale_pre", stale, 1'b0);
        tick(1);
`ifdef SEG_STALE_TIMEOUT_EN
        check("stale_set", stale, 1'b1);
`else
        check("stale_tied", stale, 1'b0);
`endif
        tick(10);
        scan4(8'hF9, 8'hA4, 8'hB0, 8'h99);
        check("stale_fv", fv_count - fv_base, 1);
        check("stale_clr", stale, 1'b0);
        check("stale_digit", digit_o, 16'h4321);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
